enemy_bullet_pool: RTL

//  Multi-shot projectile engine for one enemy tank: a pool of NUM_SLOTS bullets, each with its own direction.

---
 rtl/tank_pkg.sv | 18 +
 rtl/bullet_slot.sv | 124 ++++++++++++
 rtl/enemy_bullet_pool.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared tank-game definitions: facing directions, playfield bounds and bullet geometry.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int unsigned POS_W           = 10;
    localparam int unsigned X_MIN_DEF       = 28;
    localparam int unsigned X_MAX_DEF       = 607;
    localparam int unsigned Y_MIN_DEF       = 28;
    localparam int unsigned Y_MAX_DEF       = 447;
    localparam int unsigned BULLET_SIZE_DEF = 4;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot of the enemy projectile pool.
// Holds the slot FSM (idle/flying), the position and latched direction, the playfield bounds
// check for the next step and the pixel hit test for the VGA mux.
// Ports:
//   clk_50MHz, reset      clock, asynchronous active-low reset
//   refresh_tick          frame strobe; flying bullets step once per strobe
//   clear                 drop the bullet (collision or tank destroyed); wins over move/spawn
//   spawn                 load spawn_x/spawn_y/spawn_dir and start flying (only when idle)
//   x, y                  current VGA pixel
//   active                slot is flying
//   x_pos, y_pos          bullet top-left position
//   on                    pixel (x,y) lies inside this active bullet
module bullet_slot
    import tank_pkg::*;
#(
    parameter int unsigned BULLET_SPEED = 4,
    parameter int unsigned BULLET_SIZE  = BULLET_SIZE_DEF,
    parameter int unsigned X_MIN        = X_MIN_DEF,
    parameter int unsigned X_MAX        = X_MAX_DEF,
    parameter int unsigned Y_MIN        = Y_MIN_DEF,
    parameter int unsigned Y_MAX        = Y_MAX_DEF
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             refresh_tick,
    input  logic             clear,
    input  logic             spawn,
    input  logic [POS_W-1:0] spawn_x,
    input  logic [POS_W-1:0] spawn_y,
    input  dir_t             spawn_dir,
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic             active,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             on
);

    typedef enum logic {
        StIdle,
        StFlying
    } slot_state_e;

    slot_state_e      state_q, state_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    dir_t             dir_q, dir_d;

    // One extra bit so a step below zero shows up as a huge value and fails the bounds check.
    logic [POS_W:0] nx, ny;
    logic           oob;

    always_comb begin
        nx = {1'b0, x_q};
        ny = {1'b0, y_q};
        unique case (dir_q)
            DIR_UP:    ny = {1'b0, y_q} - (POS_W+1)'(BULLET_SPEED);
            DIR_DOWN:  ny = {1'b0, y_q} + (POS_W+1)'(BULLET_SPEED);
            DIR_LEFT:  nx = {1'b0, x_q} - (POS_W+1)'(BULLET_SPEED);
            DIR_RIGHT: nx = {1'b0, x_q} + (POS_W+1)'(BULLET_SPEED);
            default:   ;
        endcase
        oob = (nx < (POS_W+1)'(X_MIN)) || (nx > (POS_W+1)'(X_MAX)) ||
              (ny < (POS_W+1)'(Y_MIN)) || (ny > (POS_W+1)'(Y_MAX));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (spawn) begin
                        state_d = StFlying;
                        x_d     = spawn_x;
                        y_d     = spawn_y;
                        dir_d   = spawn_dir;
                    end
                end
                StFlying: begin
                    if (refresh_tick) begin
                        // Leaving the field retires the slot and freezes its last legal position.
                        if (oob) begin
                            state_d = StIdle;
                        end else begin
                            x_d = nx[POS_W-1:0];
                            y_d = ny[POS_W-1:0];
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
        end
    end

    assign active = (state_q == StFlying);
    assign x_pos  = x_q;
    assign y_pos  = y_q;

    // Widened compare so a bullet near the right/bottom edge cannot wrap its extent.
    assign on = active &&
                ({1'b0, x} >= {1'b0, x_q}) &&
                ({1'b0, x} <= {1'b0, x_q} + (POS_W+1)'(BULLET_SIZE - 1)) &&
                ({1'b0, y} >= {1'b0, y_q}) &&
                ({1'b0, y} <= {1'b0, y_q} + (POS_W+1)'(BULLET_SIZE - 1));

endmodule

// File: rtl/enemy_bullet_pool.sv
// Multi-shot projectile engine for one enemy tank.
// A pool of NUM_SLOTS independently flying bullets; shots are taken on request, limited by a
// cooldown counted in refresh ticks, and placed in the lowest-index free slot.
// Ports:
//   clk_50MHz, reset         clock, asynchronous active-low reset
//   x, y                     current VGA pixel
//   refresh_tick             frame strobe
//   fire_req                 level shoot request, sampled on refresh_tick
//   enemy_alive              0 blocks new shots
//   x_enemy, y_enemy         enemy top-left position
//   enemy_dir                enemy facing, latched per bullet at spawn
//   hit                      per-slot collision clear
//   tank_destroyed           clears every slot
//   x_bullet, y_bullet       packed positions, slot i at [10*i +: 10]
//   slot_active, slot_on     per-slot flying / pixel-inside flags
//   bullet_on                any slot covers the pixel
//   fire_ack                 one-cycle pulse after an accepted shot
module enemy_bullet_pool
    import tank_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned BULLET_SPEED   = 4,
    parameter int unsigned BULLET_SIZE    = BULLET_SIZE_DEF,
    parameter int unsigned SPAWN_OFFSET   = 14,
    parameter int unsigned COOLDOWN_TICKS = 16,
    parameter int unsigned X_MIN          = X_MIN_DEF,
    parameter int unsigned X_MAX          = X_MAX_DEF,
    parameter int unsigned Y_MIN          = Y_MIN_DEF,
    parameter int unsigned Y_MAX          = Y_MAX_DEF
) (
    input  logic                       clk_50MHz,
    input  logic                       reset,
    input  logic [POS_W-1:0]           x,
    input  logic [POS_W-1:0]           y,
    input  logic                       refresh_tick,
    input  logic                       fire_req,
    input  logic                       enemy_alive,
    input  logic [POS_W-1:0]           x_enemy,
    input  logic [POS_W-1:0]           y_enemy,
    input  dir_t                       enemy_dir,
    input  logic [NUM_SLOTS-1:0]       hit,
    input  logic                       tank_destroyed,
    output logic [POS_W*NUM_SLOTS-1:0] x_bullet,
    output logic [POS_W*NUM_SLOTS-1:0] y_bullet,
    output logic [NUM_SLOTS-1:0]       slot_active,
    output logic [NUM_SLOTS-1:0]       slot_on,
    output logic                       bullet_on,
    output logic                       fire_ack
);

    // A zero cooldown still needs a one-bit counter to keep the logic uniform.
    localparam int unsigned CntW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    logic [CntW-1:0]      cooldown_q, cooldown_d;
    logic                 fire_ack_q;
    logic [NUM_SLOTS-1:0] free, grant, spawn;
    logic                 found, accept;
    logic [POS_W-1:0]     spawn_x, spawn_y;

    // A slot being cleared this cycle is not offered to the shooter.
    assign free = ~slot_active & ~hit;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (free[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign accept = refresh_tick && fire_req && enemy_alive && (cooldown_q == '0) &&
                    found && !tank_destroyed;
    assign spawn  = accept ? grant : '0;

    assign spawn_x = x_enemy + POS_W'(SPAWN_OFFSET);
    assign spawn_y = y_enemy + POS_W'(SPAWN_OFFSET);

    always_comb begin
        cooldown_d = cooldown_q;
        if (accept) begin
            cooldown_d = CntW'(COOLDOWN_TICKS);
        end else if (refresh_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            cooldown_q <= '0;
            fire_ack_q <= 1'b0;
        end else begin
            cooldown_q <= cooldown_d;
            fire_ack_q <= accept;
        end
    end

    assign fire_ack = fire_ack_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bullet_slot #(
            .BULLET_SPEED (BULLET_SPEED),
            .BULLET_SIZE  (BULLET_SIZE),
            .X_MIN        (X_MIN),
            .X_MAX        (X_MAX),
            .Y_MIN        (Y_MIN),
            .Y_MAX        (Y_MAX)
        ) u_slot (
            .clk_50MHz    (clk_50MHz),
            .reset        (reset),
            .refresh_tick (refresh_tick),
            .clear        (hit[g] | tank_destroyed),
            .spawn        (spawn[g]),
            .spawn_x      (spawn_x),
            .spawn_y      (spawn_y),
            .spawn_dir    (enemy_dir),
            .x            (x),
            .y            (y),
            .active       (slot_active[g]),
            .x_pos        (x_bullet[POS_W*g +: POS_W]),
            .y_pos        (y_bullet[POS_W*g +: POS_W]),
            .on           (slot_on[g])
        );
    end

    assign bullet_on = |slot_on;

endmodule
